// File: rtl/ddr4_cmd_issuer.sv
// Single-request DDR4 command issuer: tracks open rows per bank and sequences
// PRE/ACT/RD/WR commands and the data burst for one outstanding request.
module ddr4_cmd_issuer #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int DQWIDTH   = 64,
  parameter int BL        = 8,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TCL       = 5,
  parameter int TCWL      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  // Request handshake: a request transfers on any cycle where req_valid && req_ready;
  // req_ready is high only in IDLE, so at most one request is ever outstanding.
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [BGWIDTH-1:0]      req_bg,
  input  logic [BAWIDTH-1:0]      req_ba,
  input  logic [ADDRWIDTH-1:0]    req_row,
  input  logic [COLWIDTH-1:0]     req_col,
  input  logic [BL*DQWIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  output logic [BL*DQWIDTH-1:0]   rsp_rdata,
  output logic                    act_n,
  output logic                    cs_n,
  output logic [ADDRWIDTH-1:0]    A,
  output logic [BGWIDTH-1:0]      bg,
  output logic [BAWIDTH-1:0]      ba,
  output logic [DQWIDTH-1:0]      dq_o,
  output logic                    dq_oe,
  input  logic [DQWIDTH-1:0]      dq_i,
  input  logic                    stall,
  output logic [3:0]              dbg_state
);

  localparam int NB   = 1 << (BGWIDTH + BAWIDTH);
  localparam int M1   = (TRP > TRCD) ? TRP : TRCD;
  localparam int M2   = (TCL > TCWL) ? TCL : TCWL;
  localparam int M3   = (M1 > M2) ? M1 : M2;
  localparam int MAXV = (M3 > BL) ? M3 : BL;
  localparam int CW   = $clog2(MAXV + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_WAIT_LAT, S_BURST, S_RESP
  } state_t;

  state_t                       state, next_state;
  logic [CW-1:0]                cnt, cnt_nx;
  logic                         q_wr;
  logic [BGWIDTH-1:0]           q_bg;
  logic [BAWIDTH-1:0]           q_ba;
  logic [ADDRWIDTH-1:0]         q_row;
  logic [COLWIDTH-1:0]          q_col;
  logic [BL*DQWIDTH-1:0]        q_wdata;
  logic [BL*DQWIDTH-1:0]        rdata;
  logic [NB-1:0]                open_bits;
  logic [ADDRWIDTH-1:0]         open_row [NB];
  logic [BGWIDTH+BAWIDTH-1:0]   acc_bank, cur_bank;
  logic                         accept, issue_pre, issue_act;

  assign acc_bank  = {req_bg, req_ba};
  assign cur_bank  = {q_bg, q_ba};
  assign accept    = (state == S_IDLE) && req_valid;
  assign dbg_state = state;

  // Wait counters are loaded with (delay - 1) on the issue cycle and count down,
  // so a delay of 1 skips the wait state entirely.
  always_comb begin
    next_state = state;
    cnt_nx     = cnt;
    issue_pre  = 1'b0;
    issue_act  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!open_bits[acc_bank])                next_state = S_ACT;
          else if (open_row[acc_bank] == req_row)  next_state = S_CAS;
          else                                     next_state = S_PRE;
        end
      end
      S_PRE: begin
        if (!stall) begin
          issue_pre = 1'b1;
          if (TRP > 1) begin
            next_state = S_WAIT_RP;
            cnt_nx     = CW'(TRP - 1);
          end else begin
            next_state = S_ACT;
          end
        end
      end
      S_WAIT_RP: begin
        if (cnt == CW'(1)) next_state = S_ACT;
        else               cnt_nx = cnt - CW'(1);
      end
      S_ACT: begin
        if (!stall) begin
          issue_act = 1'b1;
          if (TRCD > 1) begin
            next_state = S_WAIT_RCD;
            cnt_nx     = CW'(TRCD - 1);
          end else begin
            next_state = S_CAS;
          end
        end
      end
      S_WAIT_RCD: begin
        if (cnt == CW'(1)) next_state = S_CAS;
        else               cnt_nx = cnt - CW'(1);
      end
      S_CAS: begin
        if (!stall) begin
          if ((q_wr ? TCWL : TCL) > 1) begin
            next_state = S_WAIT_LAT;
            cnt_nx     = q_wr ? CW'(TCWL - 1) : CW'(TCL - 1);
          end else begin
            next_state = S_BURST;
            cnt_nx     = '0;
          end
        end
      end
      S_WAIT_LAT: begin
        if (cnt == CW'(1)) begin
          next_state = S_BURST;
          cnt_nx     = '0;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_BURST: begin
        if (cnt == CW'(BL - 1)) next_state = q_wr ? S_IDLE : S_RESP;
        else                    cnt_nx = cnt + CW'(1);
      end
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      q_wr      <= 1'b0;
      q_bg      <= '0;
      q_ba      <= '0;
      q_row     <= '0;
      q_col     <= '0;
      q_wdata   <= '0;
      rdata     <= '0;
      open_bits <= '0;
      for (int i = 0; i < NB; i++) open_row[i] <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_nx;
      if (accept) begin
        q_wr    <= req_wr;
        q_bg    <= req_bg;
        q_ba    <= req_ba;
        q_row   <= req_row;
        q_col   <= req_col;
        q_wdata <= req_wdata;
      end
      if (issue_pre) open_bits[cur_bank] <= 1'b0;
      if (issue_act) begin
        open_bits[cur_bank] <= 1'b1;
        open_row[cur_bank]  <= q_row;
      end
      if (state == S_BURST && !q_wr) rdata[int'(cnt)*DQWIDTH +: DQWIDTH] <= dq_i;
    end
  end

  // Pins default to DES; reset forces every output to its idle value immediately.
  always_comb begin
    cs_n  = 1'b1;
    act_n = 1'b1;
    A     = '0;
    if (!reset && !stall) begin
      case (state)
        S_PRE: begin
          cs_n                = 1'b0;
          A[ADDRWIDTH-1 -: 3] = 3'b010;
        end
        S_ACT: begin
          cs_n  = 1'b0;
          act_n = 1'b0;
          A     = q_row;
        end
        S_CAS: begin
          cs_n                = 1'b0;
          A[ADDRWIDTH-1 -: 3] = q_wr ? 3'b100 : 3'b101;
          A[COLWIDTH-1:0]     = q_col;
        end
        default: ;
      endcase
    end
  end

  assign bg        = reset ? '0 : q_bg;
  assign ba        = reset ? '0 : q_ba;
  assign req_ready = !reset && (state == S_IDLE);
  assign rsp_valid = !reset && (state == S_RESP);
  assign rsp_rdata = reset ? '0 : rdata;
  assign dq_oe     = !reset && (state == S_BURST) && q_wr;
  assign dq_o      = dq_oe ? q_wdata[int'(cnt)*DQWIDTH +: DQWIDTH] : '0;

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Bench for ddr4_cmd_issuer: directed vector table, reset/abort case and
// randomized requests checked against a timeline model of the command rules.
module tb_ddr4_cmd_issuer;
  localparam int TRCD = 4, TRP = 4, TCL = 5, TCWL = 4, BL = 8;
  localparam int W = 512;
  localparam int MAXC = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_wr;
  logic [1:0]    req_bg, req_ba;
  logic [16:0]   req_row;
  logic [9:0]    req_col;
  logic [511:0]  req_wdata;
  logic          rsp_valid;
  logic [511:0]  rsp_rdata;
  logic          act_n, cs_n;
  logic [16:0]   A;
  logic [1:0]    bg, ba;
  logic [63:0]   dq_o, dq_i;
  logic          dq_oe, stall;
  logic [3:0]    dbg_state;

  ddr4_cmd_issuer dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .act_n(act_n), .cs_n(cs_n), .A(A), .bg(bg), .ba(ba),
    .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i), .stall(stall), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Open-row model of the DIMM, indexed by {bg, ba}.
  bit          m_open [16];
  logic [16:0] m_row  [16];

  typedef struct {
    logic        wr;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [16:0] row;
    logic [9:0]  col;
    int          st_lo;
    int          st_hi;
    bit          hold;
    int          rst_at;
    int          exp_cas;
    int          exp_done;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] cmd_addr(input int code, input logic [16:0] row, input logic [9:0] col);
    case (code)
      1:       return 17'h08000;
      2:       return row;
      3:       return 17'h14000 | 17'(col);
      4:       return 17'h10000 | 17'(col);
      default: return 17'h0;
    endcase
  endfunction

  // Runs one request starting on the cycle where req_ready is expected high.
  // Returns with the clock positioned inside the cycle where req_ready returns.
  task automatic run_op(input logic wr, input logic [1:0] obg, input logic [1:0] oba,
                        input logic [16:0] row, input logic [9:0] col,
                        input int st_lo, input int st_hi, input bit st_rand,
                        input bit hold, input int rst_at,
                        output int obs_cas, output int obs_done);
    logic [511:0] wdata, rexp;
    logic [63:0]  rbeat [BL];
    bit           sp [MAXC];
    int           exp_cmd [MAXC];
    int           ty [3], gp [3];
    int           bank, n, t, t_cas, d0, t_rsp, done_exp, code;
    bit           live, in_data;
    for (int k = 0; k < BL; k++) begin
      wdata[k*64 +: 64] = {$urandom, $urandom};
      rbeat[k]          = {$urandom, $urandom};
      rexp[k*64 +: 64]  = rbeat[k];
    end
    for (int c = 0; c < MAXC; c++) begin
      sp[c] = (c >= st_lo && c <= st_hi) ||
              (st_rand && c >= 1 && c <= 30 && $urandom_range(0, 3) == 0);
      exp_cmd[c] = 0;
    end
    // Command list from the open-row state, then place each on the first unstalled
    // cycle at or after its earliest legal time.
    bank = int'({obg, oba});
    gp = '{0, 0, 0};
    if (m_open[bank] && m_row[bank] == row) begin
      n = 1; ty[0] = wr ? 4 : 3;
    end else if (!m_open[bank]) begin
      n = 2; ty[0] = 2; gp[0] = TRCD; ty[1] = wr ? 4 : 3;
    end else begin
      n = 3; ty[0] = 1; gp[0] = TRP; ty[1] = 2; gp[1] = TRCD; ty[2] = wr ? 4 : 3;
    end
    t = 1;
    for (int i = 0; i < n; i++) begin
      while (sp[t]) t++;
      exp_cmd[t] = ty[i];
      if (i < n - 1) t += gp[i];
    end
    t_cas    = t;
    d0       = t_cas + (wr ? TCWL : TCL);
    t_rsp    = wr ? -1 : d0 + BL;
    done_exp = wr ? d0 + BL : d0 + BL + 1;
    if (rst_at >= 0) begin
      done_exp = rst_at + 1;
      for (int b = 0; b < 16; b++) m_open[b] = 1'b0;
    end else begin
      m_open[bank] = 1'b1;
      m_row[bank]  = row;
    end

    obs_cas  = -1;
    obs_done = -1;
    for (int c = 0; c < MAXC; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        if (req_ready) begin
          obs_done = c;
          break;
        end
      end else begin
        check("ready at accept", W'(req_ready), W'(1'b1));
      end
      live    = (rst_at < 0) || (c < rst_at);
      in_data = (c >= d0) && (c < d0 + BL);
      if (c == 0) begin
        req_wr = wr; req_bg = obg; req_ba = oba; req_row = row;
        req_col = col; req_wdata = wdata;
      end
      req_valid = (c == 0) || hold;
      stall     = sp[c];
      reset     = (c == rst_at);
      dq_i      = (!wr && in_data) ? rbeat[c - d0] : {$urandom, $urandom};
      @(negedge clk);
      code = live ? exp_cmd[c] : 0;
      check($sformatf("pins c%0d", c), W'({cs_n, act_n, A}),
            W'({(code == 0), (code != 2), cmd_addr(code, row, col)}));
      if (code != 0) check($sformatf("bank c%0d", c), W'({bg, ba}), W'({obg, oba}));
      if (!live) check($sformatf("reset bank c%0d", c), W'({bg, ba}), W'(4'h0));
      check($sformatf("req_ready c%0d", c), W'(req_ready), W'(c == 0 && live));
      check($sformatf("dq_oe c%0d", c), W'(dq_oe), W'(live && wr && in_data));
      if (live && wr && in_data)
        check($sformatf("dq_o c%0d", c), W'(dq_o), W'(wdata[(c - d0)*64 +: 64]));
      if (!live) check($sformatf("reset dq_o c%0d", c), W'(dq_o), W'(64'h0));
      check($sformatf("rsp_valid c%0d", c), W'(rsp_valid), W'(live && c == t_rsp));
      if (live && c == t_rsp) check($sformatf("rsp_rdata c%0d", c), rsp_rdata, rexp);
      if (!live) check($sformatf("reset rsp_rdata c%0d", c), rsp_rdata, W'(0));
      if (!cs_n && act_n && A[16:15] == 2'b10 && obs_cas < 0) obs_cas = c;
    end
    check("done cycle vs model", W'(obs_done), W'(done_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int oc, od;
    vecs[0]  = '{1'b0, 2'd1, 2'd2, 17'h1234,  10'h008, 0, -1, 1'b0, -1, 5, 19};
    vecs[1]  = '{1'b1, 2'd1, 2'd2, 17'h1234,  10'h010, 0, -1, 1'b1, -1, 1, 13};
    vecs[2]  = '{1'b0, 2'd1, 2'd2, 17'h0001,  10'h020, 0, -1, 1'b0, -1, 9, 23};
    vecs[3]  = '{1'b0, 2'd0, 2'd0, 17'h0005,  10'h000, 1,  3, 1'b0, -1, 8, 22};
    vecs[4]  = '{1'b1, 2'd3, 2'd3, 17'h1FFFF, 10'h3FF, 0, -1, 1'b1, -1, 5, 17};
    vecs[5]  = '{1'b1, 2'd3, 2'd3, 17'h0000,  10'h000, 0, -1, 1'b0, -1, 9, 21};
    vecs[6]  = '{1'b0, 2'd1, 2'd2, 17'h0001,  10'h000, 0, -1, 1'b1, -1, 1, 15};
    vecs[7]  = '{1'b0, 2'd3, 2'd3, 17'h0000,  10'h001, 2,  6, 1'b0, -1, 1, 15};
    vecs[8]  = '{1'b1, 2'd1, 2'd2, 17'h1234,  10'h002, 9, 10, 1'b0, -1, 11, 23};
    vecs[9]  = '{1'b0, 2'd2, 2'd1, 17'h0077,  10'h003, 0, -1, 1'b0, 12, 5, 13};
    vecs[10] = '{1'b0, 2'd2, 2'd1, 17'h0077,  10'h003, 0, -1, 1'b0, -1, 5, 19};
    vecs[11] = '{1'b1, 2'd1, 2'd2, 17'h1234,  10'h004, 0, -1, 1'b0, -1, 5, 17};
    vecs[12] = '{1'b0, 2'd1, 2'd2, 17'h0002,  10'h005, 1,  2, 1'b0, -1, 11, 25};
    for (int b = 0; b < 16; b++) begin
      m_open[b] = 1'b0;
      m_row[b]  = '0;
    end

    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_bg = '0; req_ba = '0;
    req_row = '0; req_col = '0; req_wdata = '0; dq_i = '0; stall = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset req_ready", W'(req_ready), W'(1'b0));
      check("reset pins", W'({cs_n, act_n, A, bg, ba}), W'({2'b11, 21'h0}));
      check("reset dq", W'({dq_oe, dq_o}), W'(65'h0));
      check("reset rsp", W'({rsp_valid, rsp_rdata}), W'(0));
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].wr, vecs[i].bg, vecs[i].ba, vecs[i].row, vecs[i].col,
             vecs[i].st_lo, vecs[i].st_hi, 1'b0, vecs[i].hold, vecs[i].rst_at, oc, od);
      check($sformatf("vec%0d cas cycle", i), W'(oc), W'(vecs[i].exp_cas));
      check($sformatf("vec%0d done cycle", i), W'(od), W'(vecs[i].exp_done));
    end

    for (int i = 0; i < 40; i++) begin
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             17'($urandom_range(0, 2)), 10'($urandom_range(0, 1023)),
             0, -1, 1'b1, 1'($urandom_range(0, 1)), -1, oc, od);
    end

    req_valid = 1'b0;
    stall     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle req_ready", W'(req_ready), W'(1'b1));
      check("idle pins", W'({cs_n, act_n, A}), W'({2'b11, 17'h0}));
      check("idle dq_oe", W'(dq_oe), W'(1'b0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ddr4_cmd_issuer.md
DDR4_CMD_ISSUER -- requirements
Module: ddr4_cmd_issuer

Interface
REQ-001 Params: BGWIDTH 2 bank-group bits; BAWIDTH 2 bank bits; ADDRWIDTH 17 row bits; COLWIDTH 10 column bits; DQWIDTH 64 data bus; BL 8 burst length; TRCD 4, TRP 4, TCL 5, TCWL 4 cycles (all ≥1).
REQ-002 clk  in  1  sole clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid / req_ready  in / out  1 / 1  request handshake.
REQ-005 req_wr  in  1  1 = write, 0 = read.
REQ-006 req_bg, req_ba, req_row, req_col  in  BGWIDTH, BAWIDTH, ADDRWIDTH, COLWIDTH  target address.
REQ-007 req_wdata  in  BL*DQWIDTH  write burst; beat k = bits [(k+1)*DQWIDTH-1 : k*DQWIDTH].
REQ-008 rsp_valid  out  1  one-cycle pulse carrying read data; rsp_rdata  out  BL*DQWIDTH  same beat packing.
REQ-009 act_n, cs_n  out  1, 1  DDR4 command pins; A  out  ADDRWIDTH; bg  out  BGWIDTH; ba  out  BAWIDTH.
REQ-010 dq_o  out  DQWIDTH; dq_oe  out  1; dq_i  in  DQWIDTH: split data bus, tristate handled at the top level.
REQ-011 stall  in  1  DIMM sync engine busy; blocks command issue.

Function
REQ-012 Encoding: DES = cs_n 1, act_n 1, A 0. ACT = cs_n 0, act_n 0, A = row. With act_n 1, A[16:14] = {ras_n, cas_n, we_n}. RD = 101, WR = 100, PRE = 010. A[10] = 0 (no auto-precharge, single-bank PRE). A[COLWIDTH-1:0] = column for RD/WR.
REQ-013 bg/ba outputs carry the target bank on ACT/PRE/RD/WR; they are held at the last target bank otherwise.
REQ-014 Open-row table: per bank, an open bit plus a row register; all banks closed after reset.
REQ-015 One outstanding request. req_ready = 1 only in IDLE. Request is accepted on the cycle req_valid && req_ready; address and wdata are registered on acceptance.
REQ-016 FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_LAT, BURST, RESP.
REQ-017 From IDLE on accept: row hit -> CAS; bank closed -> ACT; open with a different row -> PRE.
REQ-018 PRE issues the PRE command and clears the bank's open bit, then goes to WAIT_RP. After TRP cycles counted from the PRE cycle, the FSM goes to ACT.
REQ-019 ACT issues the ACT command and sets the open bit and row, then goes to WAIT_RCD. CAS is reached TRCD cycles after the ACT cycle.
REQ-020 CAS issues RD or WR, then goes to WAIT_LAT. The first data beat is TCL (read) or TCWL (write) cycles after the CAS cycle.
REQ-021 BURST lasts exactly BL cycles, beat 0 first.
  - Write: dq_oe = 1 and dq_o = beat k.
  - Read: dq_i is sampled into beat k.
  - dq_oe = 0 at all other times.
REQ-022 Read: after the last beat, go to RESP. RESP holds rsp_valid = 1 with the full rsp_rdata for one cycle, then returns to IDLE. Write: return to IDLE directly after the last beat, with no rsp_valid.
REQ-023 Row-hit latency, counted from the accept cycle (cycle 0):
  - CAS at cycle 1.
  - Read: rsp_valid at cycle 1+TCL+BL.
  - Write: req_ready at cycle 1+TCWL+BL.
  Add TRCD for a closed bank. Add TRP+TRCD for a row conflict.
REQ-024 Stall rules:
  - While stall = 1 in PRE, ACT or CAS, the command is not issued: DES is driven and the FSM stays in that state.
  - The command issues on the first cycle stall = 0.
  - Wait counters start from the actual issue cycle.
  - stall has no effect in the WAIT_*, BURST and RESP states.
REQ-025 Outside command-issue cycles, pins are DES.
REQ-026 Counters are width clog2(max(TRP, TRCD, TCL, TCWL, BL)+1). There is no wrap within an operation.

Reset
REQ-027 reset has priority over all other inputs. While reset = 1:
  - FSM = IDLE; open-row table cleared.
  - req_ready = 0; rsp_valid = 0; rsp_rdata = 0.
  - cs_n = 1, act_n = 1; A, bg, ba = 0.
  - dq_oe = 0, dq_o = 0.
REQ-028 Reset mid-operation aborts the operation with no response. req_ready = 1 on the first cycle after reset deasserts.

Verification
REQ-029 Closed-bank read: bg 1, ba 2, row 0x1234, col 0x08.
  - Cycle 1: ACT with A = 0x1234.
  - Cycle 5: RD with A[16:14] = 101 and A[9:0] = 0x08.
  - dq_i is sampled on cycles 10-17.
  - rsp_valid at cycle 18.
REQ-030 Row-hit write to the same bank and row, col 0x10.
  - Cycle 1: WR.
  - dq_oe = 1 on cycles 5-12, beats 0..7 in order.
  - req_ready returns at cycle 13.
REQ-031 Row conflict: same bank, row 0x0001.
  - Cycle 1: PRE with A[10] = 0.
  - Cycle 5: ACT with row 0x0001.
  - Cycle 9: CAS.
REQ-032 stall held high for cycles 1-3 on a closed-bank read: DES on cycles 1-3, ACT at cycle 4, RD at cycle 8.
REQ-033 Reset pulse during BURST of a read: no rsp_valid, pins are DES, dq_oe = 0, and the table is cleared. The next request to the same bank issues ACT, not CAS.
REQ-034 Back-to-back: req_valid held high across completions is accepted once per operation. req_ready is never 1 outside IDLE.
